// File: rtl/ltl_seq_pkg.sv
// Shared types and constants for the LTL monitor sequencer.
// LTL_SEQ_TIMESTAMP_EN adds a per-entry cycle stamp to the report entry layout.
package ltl_seq_pkg;

    localparam int unsigned TS_W        = 32;
    localparam int unsigned DEF_NUM_RPT = 4;
    localparam int unsigned DEF_IDX_W   = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        ARM    = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4
    } seq_state_e;

    // Report entry layout for the default configuration (MSB first)
    typedef struct packed {
        logic [DEF_NUM_RPT-1:0] vec;
        logic [DEF_IDX_W-1:0]   idx;
`ifdef LTL_SEQ_TIMESTAMP_EN
        logic [TS_W-1:0]        cycle;
`endif
    } rpt_entry_t;

    function automatic int unsigned rpt_entry_w(input int unsigned num_rpt, input int unsigned idx_w);
`ifdef LTL_SEQ_TIMESTAMP_EN
        return num_rpt + idx_w + TS_W;
`else
        return num_rpt + idx_w;
`endif
    endfunction

endpackage

// File: rtl/ltl_seq_rpt_fifo.sv
// Generic first-word-fall-through FIFO with occupancy and free-slot outputs.
// DEPTH must be a power of two, >= 2.
module ltl_seq_rpt_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     free
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves the same cycle
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign count    = cnt;
    assign free     = CW'(DEPTH) - cnt;

endmodule

// File: rtl/ltl_monitor_sequencer.sv
// Session sequencer for one LTL STE automaton cluster: reset/arm, symbol feed, report capture.
// Optional LTL_SEQ_TIMESTAMP_EN adds a free-running cycle stamp per report entry (rpt_cycle).
module ltl_monitor_sequencer
    import ltl_seq_pkg::*;
#(
    parameter int unsigned SYM_W      = 8,
    parameter int unsigned NUM_RPT    = 4,
    parameter int unsigned IDX_W      = 32,
    parameter int unsigned RPT_DEPTH  = 4,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sess_start,
    input  logic               sess_end,
    input  logic               sym_valid,
    input  logic [SYM_W-1:0]   sym_data,
    output logic               sym_ready,
    output logic               ste_reset,
    output logic               ste_run,
    output logic [SYM_W-1:0]   ste_symbols,
    input  logic [NUM_RPT-1:0] ste_report,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [NUM_RPT-1:0] rpt_vec,
    output logic [IDX_W-1:0]   rpt_index,
`ifdef LTL_SEQ_TIMESTAMP_EN
    output logic [TS_W-1:0]    rpt_cycle,
`endif
    output logic               busy,
    output logic               done
);

    localparam int unsigned ENT_W = rpt_entry_w(NUM_RPT, IDX_W);
    localparam int unsigned CW    = $clog2(RPT_DEPTH) + 1;
    localparam int unsigned FC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    seq_state_e        state;
    seq_state_e        state_nxt;
    logic [FC_W-1:0]   flush_cnt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_d1;
    logic              run_d1;
    logic              run_c;
    logic              space_ok;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [ENT_W-1:0]  fifo_wr;
    logic [ENT_W-1:0]  fifo_rd;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     fifo_free;

    // A symbol in flight may still push next cycle, so reserve its slot
    assign space_ok = (fifo_free > CW'(run_d1));

    // Next-state and run gating
    always_comb begin
        state_nxt = state;
        run_c     = 1'b0;
        case (state)
            IDLE:   if (sess_start) state_nxt = FLUSH;
            FLUSH:  if (flush_cnt == FC_W'(RST_CYCLES - 1)) state_nxt = ARM;
            ARM:    if (sym_valid && !fifo_full) state_nxt = STREAM;
            STREAM: begin
                run_c = sym_valid & space_ok;
                if (sess_end) state_nxt = DRAIN;
            end
            DRAIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            flush_cnt <= '0;
            idx       <= '0;
            idx_d1    <= '0;
            run_d1    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state  <= state_nxt;
            done   <= (state == DRAIN);
            run_d1 <= run_c;
            flush_cnt <= (state == FLUSH) ? flush_cnt + FC_W'(1) : '0;
            if (state == IDLE && sess_start) begin
                idx <= '0;
            end else if (run_c) begin
                idx_d1 <= idx;
                idx    <= idx + IDX_W'(1);
            end
        end
    end

    assign sym_ready   = run_c;
    assign ste_run     = run_c;
    assign ste_symbols = sym_data;
    assign ste_reset   = reset | (state == FLUSH) | (state == ARM);
    assign busy        = (state != IDLE);

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_free == '0);
    assign fifo_push  = run_d1 & (|ste_report);
    assign fifo_pop   = ~fifo_empty & rpt_ready;

`ifdef LTL_SEQ_TIMESTAMP_EN
    logic [TS_W-1:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (reset) cycle_cnt <= '0;
        else       cycle_cnt <= cycle_cnt + TS_W'(1);
    end

    assign fifo_wr   = {ste_report, idx_d1, cycle_cnt};
    assign rpt_cycle = fifo_rd[TS_W-1:0];
`else
    assign fifo_wr   = {ste_report, idx_d1};
`endif

    ltl_seq_rpt_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (RPT_DEPTH)
    ) u_rpt_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_wr),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .count     (fifo_count),
        .free      (fifo_free)
    );

    assign rpt_valid = ~fifo_empty;
    assign rpt_vec   = fifo_rd[ENT_W-1 -: NUM_RPT];
    assign rpt_index = fifo_rd[ENT_W-NUM_RPT-1 -: IDX_W];

endmodule

// File: tb/tb_ltl_monitor_sequencer.sv
// Self-checking bench for ltl_monitor_sequencer: directed vector table, corner sequences, random sessions.
module tb_ltl_monitor_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sess_start, sess_end, sym_valid, rpt_ready;
    logic [7:0]  sym_data;
    logic        sym_ready, ste_reset, ste_run, rpt_valid, busy, done;
    logic [7:0]  ste_symbols;
    logic [3:0]  ste_report, rpt_vec;
    logic [31:0] rpt_index;
`ifdef LTL_SEQ_TIMESTAMP_EN
    logic [31:0] rpt_cycle;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ltl_monitor_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .sess_start  (sess_start),
        .sess_end    (sess_end),
        .sym_valid   (sym_valid),
        .sym_data    (sym_data),
        .sym_ready   (sym_ready),
        .ste_reset   (ste_reset),
        .ste_run     (ste_run),
        .ste_symbols (ste_symbols),
        .ste_report  (ste_report),
        .rpt_valid   (rpt_valid),
        .rpt_ready   (rpt_ready),
        .rpt_vec     (rpt_vec),
        .rpt_index   (rpt_index),
`ifdef LTL_SEQ_TIMESTAMP_EN
        .rpt_cycle   (rpt_cycle),
`endif
        .busy        (busy),
        .done        (done)
    );

    // Stand-in cluster: report of a consumed symbol appears one cycle later
    function automatic logic [3:0] clus_f(input logic [7:0] s);
        return (s[1:0] == 2'b00) ? 4'h0 : s[7:4];
    endfunction

    logic       use_model = 1'b0;
    logic [3:0] force_rpt = 4'h0;
    logic [3:0] model_rpt;

    always @(posedge clk) begin
        if (reset) model_rpt <= 4'h0;
        else       model_rpt <= ste_run ? clus_f(ste_symbols) : 4'h0;
    end

    assign ste_report = use_model ? model_rpt : force_rpt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic en, input logic v, input logic [7:0] d, input logic rr);
        sess_start = st;
        sess_end   = en;
        sym_valid  = v;
        sym_data   = d;
        rpt_ready  = rr;
        #1;
    endtask

    task automatic pop_check(input string name, input logic [3:0] ev, input logic [31:0] ei);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk({name, "_valid"}, 64'(rpt_valid), 64'd1);
        chk({name, "_vec"},   64'(rpt_vec),   64'(ev));
        chk({name, "_idx"},   64'(rpt_index), 64'(ei));
        adv();
    endtask

    typedef struct {
        logic       st, en, v;
        logic [7:0] d;
        logic [3:0] r;
        logic       e_rst, e_run, e_busy, e_done, e_rv;
    } vec_t;

    vec_t tbl [10];

    // Random-phase reference: ordered queue of expected {vec, index} entries
    logic [35:0] mq [$];
    logic        last_acc;
    logic [7:0]  last_sym;
    logic [31:0] last_idx;
    logic [31:0] model_idx;
    logic        seen_done;

    task automatic rcycle(input logic st, input logic en);
        logic acc, popq;
        drive(st, en, ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
        seen_done = done;
        chk("rnd_rpt_valid", 64'(rpt_valid), 64'(mq.size() != 0));
        if (rpt_valid && mq.size() != 0)
            chk("rnd_entry", 64'({rpt_vec, rpt_index}), 64'(mq[0]));
        chk("rnd_ready_needs_valid", 64'(sym_ready & ~sym_valid), 64'd0);
        acc  = sym_valid & sym_ready;
        popq = rpt_valid & rpt_ready;
        if (popq && mq.size() != 0) void'(mq.pop_front());
        if (last_acc && clus_f(last_sym) != 4'h0) mq.push_back({clus_f(last_sym), last_idx});
        chk("rnd_no_overflow", 64'(mq.size() <= 4), 64'd1);
        last_acc = acc;
        if (acc) begin
            last_sym  = sym_data;
            last_idx  = model_idx;
            model_idx = model_idx + 32'd1;
        end
        adv();
    endtask

    initial begin
        int acc_cnt;
        int k;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        adv();
        adv();
        chk("rst_ste_reset", 64'(ste_reset), 64'd1);
        chk("rst_sym_ready", 64'(sym_ready), 64'd0);
        chk("rst_ste_run",   64'(ste_run),   64'd0);
        chk("rst_rpt_valid", 64'(rpt_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(done),      64'd0);
        reset = 1'b0;
        adv();

        // Session: reset hold, stream 08/00/80, bit1 report on third symbol, end with report pending
        tbl[0] = '{1'b1, 1'b0, 1'b1, 8'h08, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h08, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h08, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h08, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h08, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 8'h80, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            force_rpt = tbl[i].r;
            drive(tbl[i].st, tbl[i].en, tbl[i].v, tbl[i].d, 1'b0);
            chk($sformatf("tbl%0d_ste_reset", i), 64'(ste_reset),   64'(tbl[i].e_rst));
            chk($sformatf("tbl%0d_ste_run", i),   64'(ste_run),     64'(tbl[i].e_run));
            chk($sformatf("tbl%0d_sym_ready", i), 64'(sym_ready),   64'(tbl[i].e_run));
            chk($sformatf("tbl%0d_busy", i),      64'(busy),        64'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_done", i),      64'(done),        64'(tbl[i].e_done));
            chk($sformatf("tbl%0d_rpt_valid", i), 64'(rpt_valid),   64'(tbl[i].e_rv));
            chk($sformatf("tbl%0d_symbols", i),   64'(ste_symbols), 64'(tbl[i].d));
            adv();
        end
        force_rpt = 4'h0;
        pop_check("tbl_entry", 4'b0010, 32'd2);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("tbl_single_entry", 64'(rpt_valid), 64'd0);

        // Gaps in sym_valid: run follows valid, indices stay contiguous
        use_model = 1'b1;
        adv();
        drive(1'b1, 1'b0, 1'b0, 8'h51, 1'b0); adv();
        drive(1'b0, 1'b0, 1'b0, 8'h51, 1'b0); adv();
        drive(1'b0, 1'b0, 1'b0, 8'h51, 1'b0); adv();
        drive(1'b0, 1'b0, 1'b1, 8'h51, 1'b0);
        chk("gap_arm_no_run", 64'(ste_run), 64'd0);
        adv();
        for (int i = 0; i < 4; i++) begin
            logic p;
            p = (i == 0 || i == 3);
            drive(1'b0, 1'b0, p, 8'h51, 1'b0);
            chk($sformatf("gap_run%0d", i), 64'(ste_run), 64'(p));
            adv();
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0); adv();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); adv();
        adv();
        pop_check("gap_e0", 4'h5, 32'd0);
        pop_check("gap_e1", 4'h5, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("gap_two_entries", 64'(rpt_valid), 64'd0);
        adv();

        // Backpressure: FIFO fills, sym_ready stops, one pop re-enables
        drive(1'b1, 1'b0, 1'b0, 8'h51, 1'b0); adv();
        drive(1'b0, 1'b0, 1'b0, 8'h51, 1'b0); adv();
        drive(1'b0, 1'b0, 1'b0, 8'h51, 1'b0); adv();
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h51, 1'b0);
            if (sym_ready) acc_cnt++;
            adv();
        end
        chk("full_accepts", 64'(acc_cnt), 64'd4);
        drive(1'b0, 1'b0, 1'b1, 8'h51, 1'b0);
        chk("full_ready_low", 64'(sym_ready), 64'd0);
        adv();
        drive(1'b0, 1'b0, 1'b1, 8'h51, 1'b1);
        chk("full_pop_idx", 64'(rpt_index), 64'd0);
        chk("full_pop_conservative", 64'(sym_ready), 64'd0);
        adv();
        drive(1'b0, 1'b1, 1'b1, 8'h51, 1'b0);
        chk("full_ready_again", 64'(sym_ready), 64'd1);
        adv();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); adv();
        for (int i = 1; i <= 4; i++) pop_check($sformatf("full_e%0d", i), 4'h5, 32'(i));
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("full_drained", 64'(rpt_valid), 64'd0);
        adv();

        // Reset mid-STREAM with reports pending
        drive(1'b1, 1'b0, 1'b0, 8'h51, 1'b0); adv();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h51, 1'b0);
            adv();
        end
        reset = 1'b1;
        #1;
        chk("mid_rst_ste_reset", 64'(ste_reset), 64'd1);
        adv();
        chk("mid_rst_busy",      64'(busy),      64'd0);
        chk("mid_rst_rpt_valid", 64'(rpt_valid), 64'd0);
        chk("mid_rst_sym_ready", 64'(sym_ready), 64'd0);
        chk("mid_rst_ste_run",   64'(ste_run),   64'd0);
        chk("mid_rst_done",      64'(done),      64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ste_reset", 64'(ste_reset), 64'd0);
        adv();

        // Random sessions against the queue reference
        last_acc  = 1'b0;
        last_sym  = 8'h00;
        last_idx  = 32'd0;
        model_idx = 32'd0;
        for (int s = 0; s < 8; s++) begin
            model_idx = 32'd0;
            rcycle(1'b1, 1'b0);
            for (int n = 0; n < int'($urandom_range(5, 40)); n++) rcycle(1'b0, 1'b0);
            seen_done = 1'b0;
            k = 0;
            while (!seen_done && k < 300) begin
                rcycle(1'b0, 1'b1);
                k++;
            end
            chk("rnd_session_done", 64'(seen_done), 64'd1);
        end
        for (int i = 0; i < 12; i++) rcycle(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
